// File: rtl/proc_trace_monitor.sv
// rtl/proc_trace_monitor.sv - commit-trace recorder with cycle stamps and show-ahead FIFO (optional macro TRACE_PC_EN)
module proc_trace_monitor #(
    parameter int DEPTH       = 16,
    parameter int CW          = 16,
    parameter int CYCLE_LIMIT = 100,
`ifdef TRACE_PC_EN
    localparam int ENTRY_W    = CW + 115,
`else
    localparam int ENTRY_W    = CW + 83,
`endif
    localparam int AW         = $clog2(DEPTH),
    localparam int CNT_W      = AW + 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ctrl_writeEnable,
    input  logic [4:0]         ctrl_writeReg,
    input  logic [31:0]        data_writeReg,
    input  logic               wren,
    input  logic [11:0]        address_dmem,
    input  logic [31:0]        data,
    input  logic [31:0]        pc,
    input  logic               rd_en,
    output logic               rd_valid,
    output logic [ENTRY_W-1:0] rd_data,
    output logic [CNT_W-1:0]   count,
    output logic               overflow,
    output logic [7:0]         drops,
    output logic               done
);

    logic [CW-1:0]      cyc_q, cyc_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               overflow_q, overflow_d;
    logic [7:0]         drops_q, drops_d;
    logic [ENTRY_W-1:0] mem_q [DEPTH];

    logic               rf_v;
    logic               dm_v;
    logic               evt;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               drop;
    logic [ENTRY_W-1:0] entry_d;

`ifndef TRACE_PC_EN
    logic unused_pc;
    assign unused_pc = ^pc;
`endif

    // Qualify events, build the entry and decide push / pop / drop for this cycle
    always_comb begin
        rf_v  = ctrl_writeEnable && (ctrl_writeReg != 5'd0);
        dm_v  = wren;
        evt   = (rf_v || dm_v) && !done;
        full  = (cnt_q == CNT_W'(DEPTH));
        empty = (cnt_q == '0);
        pop   = rd_en && !empty;
        // A full FIFO still accepts the event when the head leaves on the same edge
        push  = evt && (!full || rd_en);
        drop  = evt && full && !rd_en;
        entry_d = {
`ifdef TRACE_PC_EN
            pc,
`endif
            cyc_q,
            rf_v, rf_v ? ctrl_writeReg : 5'd0, rf_v ? data_writeReg : 32'd0,
            dm_v, dm_v ? address_dmem : 12'd0, dm_v ? data : 32'd0
        };
    end

    // Next-state for cycle counter, pointers, occupancy and drop accounting
    always_comb begin
        cyc_d      = cyc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        overflow_d = overflow_q;
        drops_d    = drops_q;
        if (!done) begin
            cyc_d = cyc_q + CW'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        if (drop) begin
            overflow_d = 1'b1;
            if (drops_q != 8'hFF) begin
                drops_d = drops_q + 8'd1;
            end
        end
    end

    // Control state registers, cleared asynchronously so a reset drops the trace at once
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cyc_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
            drops_q    <= 8'd0;
        end else begin
            cyc_q      <= cyc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
            drops_q    <= drops_d;
        end
    end

    // Entry storage; contents are only observable through the occupancy-gated head
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= entry_d;
        end
    end

    // Show-ahead head and status outputs
    always_comb begin
        done     = (cyc_q == CW'(CYCLE_LIMIT));
        rd_valid = !empty;
        rd_data  = empty ? '0 : mem_q[rd_ptr_q];
        count    = cnt_q;
        overflow = overflow_q;
        drops    = drops_q;
    end

endmodule

// File: tb/tb_proc_trace_monitor.sv
// tb/tb_proc_trace_monitor.sv - scoreboard bench for proc_trace_monitor
module tb_proc_trace_monitor;

    localparam int DEPTH = 4;
    localparam int CW    = 16;
    localparam int CL    = 300;
`ifdef TRACE_PC_EN
    localparam int EW    = CW + 115;
`else
    localparam int EW    = CW + 83;
`endif
    localparam int CNTW  = $clog2(DEPTH) + 1;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            ctrl_writeEnable = 1'b0;
    logic [4:0]      ctrl_writeReg = '0;
    logic [31:0]     data_writeReg = '0;
    logic            wren = 1'b0;
    logic [11:0]     address_dmem = '0;
    logic [31:0]     data = '0;
    logic [31:0]     pc = '0;
    logic            rd_en = 1'b0;
    logic            rd_valid;
    logic [EW-1:0]   rd_data;
    logic [CNTW-1:0] count;
    logic            overflow;
    logic [7:0]      drops;
    logic            done;

    proc_trace_monitor #(.DEPTH(DEPTH), .CW(CW), .CYCLE_LIMIT(CL)) dut (
        .clock(clock), .reset(reset),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
        .data_writeReg(data_writeReg), .wren(wren), .address_dmem(address_dmem),
        .data(data), .pc(pc), .rd_en(rd_en), .rd_valid(rd_valid),
        .rd_data(rd_data), .count(count), .overflow(overflow),
        .drops(drops), .done(done)
    );

    always #5 clock = ~clock;

    int            total = 0;
    int            bad = 0;
    int            m_cyc = 0;
    int            m_cnt = 0;
    int            m_drops = 0;
    bit            m_ovf = 1'b0;
    int            pops_seen = 0;
    logic [EW-1:0] sb [$];

    task automatic chk(input string nm, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] build(input logic [31:0] pcv, input int stamp,
            input logic rfv, input logic [4:0] rg, input logic [31:0] rdat,
            input logic dmv, input logic [11:0] ad, input logic [31:0] dd);
        logic [EW-1:0] e;
        logic [CW-1:0] st;
        st = CW'(stamp);
`ifdef TRACE_PC_EN
        e = {pcv, st, rfv, rg, rdat, dmv, ad, dd};
`else
        e = {st, rfv, rg, rdat, dmv, ad, dd};
        if (pcv == 32'hFFFF_FFFF) e = '0;
`endif
        return e;
    endfunction

    function automatic logic [EW-1:0] mk_entry(input int stamp);
        logic rv;
        rv = ctrl_writeEnable && (ctrl_writeReg != 5'd0);
        return build(pc == 32'hFFFF_FFFF ? 32'hFFFF_FFFE : pc, stamp,
                     rv, rv ? ctrl_writeReg : 5'd0, rv ? data_writeReg : 32'd0,
                     wren, wren ? address_dmem : 12'd0, wren ? data : 32'd0);
    endfunction

    // Advance one clock and apply the trace rules to the inputs that were present at that edge
    task automatic tick();
        bit ev;
        bit pop;
        @(posedge clock);
        #1;
        ev  = ((ctrl_writeEnable && ctrl_writeReg != 5'd0) || wren) && (m_cyc < CL);
        pop = rd_en && (m_cnt > 0);
        if (ev) begin
            if (m_cnt < DEPTH || rd_en) begin
                sb.push_back(mk_entry(m_cyc));
                m_cnt++;
            end else begin
                m_ovf = 1'b1;
                if (m_drops < 255) m_drops++;
            end
        end
        if (pop) m_cnt--;
        if (m_cyc < CL) m_cyc++;
    endtask

    task automatic drive(input logic we, input logic [4:0] rg, input logic [31:0] wd,
            input logic wr, input logic [11:0] ad, input logic [31:0] dd, input logic re);
        ctrl_writeEnable = we; ctrl_writeReg = rg; data_writeReg = wd;
        wren = wr; address_dmem = ad; data = dd; rd_en = re;
        pc = (pc == 32'hFFFF_FFFE) ? 32'd0 : pc;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 12'd0, 32'd0, 1'b0);
        pc = 32'd0;
    endtask

    // Assert reset between edges, confirm the asynchronous clear, then release after one edge
    task automatic do_reset();
        idle();
        #2;
        reset = 1'b1;
        #1;
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_done", done, 0);
        chk("rst_drops", drops, 0);
        chk("rst_rd_data", rd_data, 0);
        m_cyc = 0; m_cnt = 0; m_drops = 0; m_ovf = 1'b0;
        sb.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 5'd0, 32'd0, 1'b0, 12'd0, 32'd0, 1'b1);
            tick();
        end
        idle();
    endtask

    // Monitor: compare status every cycle and pop the scoreboard whenever the DUT pops
    always @(negedge clock) begin
        chk("count", count, m_cnt);
        chk("rd_valid", rd_valid, m_cnt > 0);
        chk("overflow", overflow, m_ovf);
        chk("drops", drops, m_drops);
        chk("done", done, m_cyc == CL);
        if (rd_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_empty got=rd_valid want=no_entry");
            end else begin
                chk("rd_data", rd_data, sb[0]);
                if (rd_en) begin
                    void'(sb.pop_front());
                    pops_seen++;
                end
            end
        end else begin
            chk("rd_data_idle", rd_data, 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int len;
        int rd_pct;
        do_reset();

        // Basic capture at cycle 3
        idle();
        tick(); tick(); tick();
        drive(1'b1, 5'd5, 32'h2A, 1'b0, 12'd0, 32'd0, 1'b0);
        tick();
        idle();
        #3;
        chk("basic_entry", rd_data, build(32'd0, 3, 1'b1, 5'd5, 32'h2A, 1'b0, 12'd0, 32'd0));
        chk("basic_count", count, 1);
        drain(1);

        // r0 filtered, then dual-channel entry
        drive(1'b1, 5'd0, 32'h55, 1'b0, 12'd0, 32'd0, 1'b0);
        tick();
        st = m_cyc;
        drive(1'b1, 5'd7, 32'd1, 1'b1, 12'h010, 32'd9, 1'b0);
        tick();
        idle();
        #3;
        chk("dual_count", count, 1);
        chk("dual_entry", rd_data, build(32'd0, st, 1'b1, 5'd7, 32'd1, 1'b1, 12'h010, 32'd9));
        drain(1);

        // Overflow, then full with simultaneous push and pop
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 5'd1, 32'(i + 100), 1'b0, 12'd0, 32'd0, 1'b0);
            tick();
        end
        idle();
        #3;
        chk("ovf_count", count, 4);
        chk("ovf_flag", overflow, 1);
        chk("ovf_drops", drops, 2);
        chk("ovf_head", rd_data, build(32'd0, 0, 1'b1, 5'd1, 32'd100, 1'b0, 12'd0, 32'd0));
        drive(1'b1, 5'd2, 32'hBEEF, 1'b0, 12'd0, 32'd0, 1'b1);
        tick();
        idle();
        #3;
        chk("fullpp_count", count, 4);
        chk("fullpp_drops", drops, 2);
        chk("fullpp_head", rd_data, build(32'd0, 1, 1'b1, 5'd1, 32'd101, 1'b0, 12'd0, 32'd0));
        drain(4);

        // Cycle limit with continuous events and continuous reads
        do_reset();
        pops_seen = 0;
        for (int i = 0; i < CL + 20; i++) begin
            drive(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'($urandom), 12'($urandom), $urandom, 1'b1);
            pc = $urandom;
            tick();
        end
        drain(3);
        #3;
        chk("limit_pops", pops_seen, CL);
        chk("limit_drops", drops, 0);
        chk("limit_done", done, 1);

        // Drop counter saturation
        do_reset();
        for (int i = 0; i < CL + 5; i++) begin
            drive(1'b0, 5'd0, 32'd0, 1'b1, 12'($urandom), $urandom, 1'b0);
            tick();
        end
        idle();
        #3;
        chk("sat_drops", drops, 255);
        chk("sat_count", count, 4);
        drain(4);

        // Reset with three entries buffered
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 5'd0, 32'd0, 1'b1, 12'(i), 32'(i), 1'b0);
            tick();
        end
        idle();
        #1;
        chk("pre_rst_count", count, 3);
        do_reset();

        // Randomised episodes with occasional mid-run resets
        for (int ep = 0; ep < 6; ep++) begin
            do_reset();
            len = $urandom_range(60, 340);
            rd_pct = $urandom_range(10, 90);
            for (int i = 0; i < len; i++) begin
                drive(1'($urandom), ($urandom % 4 == 0) ? 5'd0 : 5'($urandom), $urandom,
                      1'($urandom), 12'($urandom), $urandom, $urandom_range(0, 99) < rd_pct);
                pc = $urandom;
                tick();
                if ($urandom_range(0, 99) == 0) do_reset();
            end
            drain(DEPTH + 1);
        end

        idle();
        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
